// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing scan controller for a 4-digit seven-segment display.
//   It sequences the select lines of a shared 4:1 digit-data mux and drives
//   the matching active-low anodes. Each digit slot opens with a blanking
//   interval so the mux data can settle before its anode lights.
//
// Parameters
//   PRESCALE  clock cycles per digit slot (>= 2)
//   BLANK     blanked cycles at the start of each slot (0 <= BLANK < PRESCALE)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          scan enable; low blanks the display and freezes the digit index
//   digit_en    per-digit lit mask (bit d = 0 keeps digit d dark)
//   sel         mux select, drives 3 - d so the mux routes digit d's data
//   an          active-low digit anodes
//   blank       high while every anode is off
//   frame_tick  one-cycle pulse in the first cycle of slot 0
module display_scan_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       blank,
  output logic       frame_tick
);

  if (PRESCALE < 2 || BLANK < 0 || BLANK >= PRESCALE) begin : g_bad_params
    $error("display_scan_ctrl: need PRESCALE >= 2 and 0 <= BLANK < PRESCALE");
  end

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  // S_IDLE: state (d, cnt=0) is held but the display is dark (after reset or
  // while en is low). The first enabled edge out of S_IDLE does not advance
  // the counter, so the held slot restarts with a full blank phase.
  typedef enum logic {
    S_IDLE,
    S_RUN
  } scan_state_e;

  scan_state_e   state_q, state_d;
  logic [1:0]    d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q, an_d;
  logic          blank_q, blank_d;
  logic          frame_tick_q, frame_tick_d;

  logic          in_show;
  logic          lit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      d_q          <= '0;
      cnt_q        <= '0;
      sel_q        <= '1;
      an_q         <= '1;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      d_q          <= d_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      blank_q      <= blank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      d_d   = d_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Phase decode of the next counter value; with no blank interval every
  // count is in the show phase (kept out of a compare against zero).
  if (BLANK == 0) begin : g_no_blank
    assign in_show = 1'b1;
  end else begin : g_blank
    assign in_show = (cnt_d >= CW'(BLANK));
  end

  // Outputs are decoded from the next state and registered, so each output
  // matches the (d, cnt) held in the same cycle.
  always_comb begin
    lit          = en && in_show && digit_en[d_d];
    an_d         = lit ? ~(4'b0001 << d_d) : 4'b1111;
    blank_d      = ~lit;
    frame_tick_d = en && (d_d == 2'd0) && (cnt_d == '0);
    sel_d        = ~d_d;
  end

  assign sel        = sel_q;
  assign an         = an_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;

endmodule
